// File: rtl/axi4_lite_slave_pkg.sv
// Shared types, response codes and address helpers for the AXI4-Lite register-array responder.
package axi4_lite_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_A,
    WR_HAVE_D,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  // Word index of a byte address, wrapped modulo the array depth.
  function automatic logic [31:0] addr_to_index(input logic [63:0] addr,
                                                input logic [63:0] base,
                                                input int unsigned off_bits,
                                                input int unsigned depth);
    logic [63:0] word;
    word = (addr - base) >> off_bits;
    return 32'(word % 64'(depth));
  endfunction

  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input int unsigned off_bits,
                                         input int unsigned depth);
    logic [63:0] word;
    word = (addr - base) >> off_bits;
    return (addr >= base) && (word < 64'(depth));
  endfunction

endpackage

// File: rtl/axi4_lite_slave_regarray.sv
// Byte-enabled word array: one write port, one registered read port, asynchronous clear of all contents.
module axi4_lite_slave_regarray #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 16,
  parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_re,
  input  logic [IDX_W-1:0]        i_raddr,
  input  logic                    i_rzero,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [BYTES-1:0][7:0] r_mem [MEM_DEPTH];
  logic [BYTES-1:0][7:0] w_wbytes;
  logic [DATA_WIDTH-1:0] r_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign w_wbytes[gi] = i_wdata[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < MEM_DEPTH; d++) begin
        r_mem[d] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b] <= w_wbytes[b];
        end
      end
    end
  end

  // Non-blocking read sees the pre-write contents when a write lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_rzero ? '0 : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite responder over a byte-enabled register array; independent write and read FSMs.
// Define AXI4LITE_SLV_ADDR_CHECK_EN to answer out-of-range addresses with SLVERR instead of wrapping.
module axi4_lite_slave_mem
  import axi4_lite_slave_pkg::*;
#(
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       MEM_DEPTH     = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [DATA_WIDTH/8-1:0]  wstrb,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [1:0]               bresp,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp
);

  localparam int unsigned BYTES    = DATA_WIDTH / 8;
  localparam int unsigned OFF_BITS = $clog2(BYTES);
  localparam int          IDX_W    = $clog2(MEM_DEPTH);

  wr_state_t r_wr_state, w_wr_state_next;
  rd_state_t r_rd_state, w_rd_state_next;

  logic [IDX_W-1:0]      w_aw_idx, w_ar_idx, r_aw_idx, w_cm_idx;
  logic                  w_aw_ok, w_ar_ok, r_aw_ok, w_cm_ok;
  logic [DATA_WIDTH-1:0] r_wdata, w_cm_data;
  logic [BYTES-1:0]      r_wstrb, w_cm_strb;
  logic                  w_aw_hs, w_w_hs, w_commit, w_rd_capture;
  logic [1:0]            r_bresp, r_rresp;

  assign w_aw_idx = IDX_W'(addr_to_index(64'(awaddr), 64'(BASE_ADDR), OFF_BITS, MEM_DEPTH));
  assign w_ar_idx = IDX_W'(addr_to_index(64'(araddr), 64'(BASE_ADDR), OFF_BITS, MEM_DEPTH));

`ifdef AXI4LITE_SLV_ADDR_CHECK_EN
  assign w_aw_ok = addr_in_range(64'(awaddr), 64'(BASE_ADDR), OFF_BITS, MEM_DEPTH);
  assign w_ar_ok = addr_in_range(64'(araddr), 64'(BASE_ADDR), OFF_BITS, MEM_DEPTH);
`else
  assign w_aw_ok = 1'b1;
  assign w_ar_ok = 1'b1;
`endif

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;

  // Whichever half arrives on the committing edge comes straight from the bus; the other from holding regs.
  assign w_cm_idx  = (r_wr_state == WR_HAVE_A) ? r_aw_idx : w_aw_idx;
  assign w_cm_ok   = (r_wr_state == WR_HAVE_A) ? r_aw_ok  : w_aw_ok;
  assign w_cm_data = (r_wr_state == WR_HAVE_D) ? r_wdata  : wdata;
  assign w_cm_strb = (r_wr_state == WR_HAVE_D) ? r_wstrb  : wstrb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= WR_IDLE;
    end else begin
      r_wr_state <= w_wr_state_next;
    end
  end

  always_comb begin
    w_wr_state_next = r_wr_state;
    awready         = 1'b0;
    wready          = 1'b0;
    bvalid          = 1'b0;
    w_commit        = 1'b0;
    case (r_wr_state)
      WR_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (awvalid && wvalid) begin
          w_wr_state_next = WR_RESP;
          w_commit        = 1'b1;
        end else if (awvalid) begin
          w_wr_state_next = WR_HAVE_A;
        end else if (wvalid) begin
          w_wr_state_next = WR_HAVE_D;
        end
      end
      WR_HAVE_A: begin
        wready = 1'b1;
        if (wvalid) begin
          w_wr_state_next = WR_RESP;
          w_commit        = 1'b1;
        end
      end
      WR_HAVE_D: begin
        awready = 1'b1;
        if (awvalid) begin
          w_wr_state_next = WR_RESP;
          w_commit        = 1'b1;
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          w_wr_state_next = WR_IDLE;
        end
      end
      default: w_wr_state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_idx <= '0;
      r_aw_ok  <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_idx <= w_aw_idx;
        r_aw_ok  <= w_aw_ok;
      end
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_commit) begin
        r_bresp <= w_cm_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign bresp = r_bresp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= RD_IDLE;
    end else begin
      r_rd_state <= w_rd_state_next;
    end
  end

  always_comb begin
    w_rd_state_next = r_rd_state;
    arready         = 1'b0;
    rvalid          = 1'b0;
    w_rd_capture    = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          w_rd_state_next = RD_DATA;
          w_rd_capture    = 1'b1;
        end
      end
      RD_DATA: begin
        rvalid = 1'b1;
        if (rready) begin
          w_rd_state_next = RD_IDLE;
        end
      end
      default: w_rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rresp <= RESP_OKAY;
    end else if (w_rd_capture) begin
      r_rresp <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign rresp = r_rresp;

  axi4_lite_slave_regarray #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_regarray (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_commit && w_cm_ok),
    .i_waddr (w_cm_idx),
    .i_wdata (w_cm_data),
    .i_wstrb (w_cm_strb),
    .i_re    (w_rd_capture),
    .i_raddr (w_ar_idx),
    .i_rzero (!w_ar_ok),
    .o_rdata (rdata)
  );

endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Directed self-checking bench for axi4_lite_slave_mem (default 32-bit data, 16 words, base 0).
module tb_axi4_lite_slave_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef AXI4LITE_SLV_ADDR_CHECK_EN
  localparam logic [1:0]  OOR_RESP  = 2'b10;
  localparam logic [31:0] OOR_RDATA = 32'h0;
  localparam logic [31:0] OOR_WORD0 = 32'hAA22CC44;
`else
  localparam logic [1:0]  OOR_RESP  = 2'b00;
  localparam logic [31:0] OOR_RDATA = 32'hCAFEF00D;
  localparam logic [31:0] OOR_WORD0 = 32'hCAFEF00D;
`endif

  always #5 clk = ~clk;

  axi4_lite_slave_mem dut (
    .clk     (clk),
    .rst     (rst),
    .awvalid (awvalid),
    .awready (awready),
    .awaddr  (awaddr),
    .wvalid  (wvalid),
    .wready  (wready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .bvalid  (bvalid),
    .bready  (bready),
    .bresp   (bresp),
    .arvalid (arvalid),
    .arready (arready),
    .araddr  (araddr),
    .rvalid  (rvalid),
    .rready  (rready),
    .rdata   (rdata),
    .rresp   (rresp)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp, input string tag);
    int   n;
    logic aw_hs, w_hs;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk);
      #1;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      n++;
    end
    check({tag, " hs_pending"}, 64'(awvalid || wvalid), 0);
    awvalid = 1'b0; wvalid = 1'b0;
    check({tag, " bvalid"}, 64'(bvalid), 1);
    check({tag, " bresp"}, 64'(bresp), 64'(exp_resp));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check({tag, " bvalid_drop"}, 64'(bvalid), 0);
    $display("[TB] write %s addr=%08h data=%08h strb=%h bresp=%b", tag, addr, data, strb, bresp);
  endtask

  task automatic read_txn(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string tag);
    int   n;
    logic ar_hs;
    araddr = addr; arvalid = 1'b1; n = 0;
    while (arvalid && n < 20) begin
      @(negedge clk);
      ar_hs = arvalid && arready;
      @(posedge clk);
      #1;
      if (ar_hs) arvalid = 1'b0;
      n++;
    end
    check({tag, " ar_pending"}, 64'(arvalid), 0);
    arvalid = 1'b0;
    check({tag, " rvalid"}, 64'(rvalid), 1);
    check({tag, " rdata"}, 64'(rdata), 64'(exp_data));
    check({tag, " rresp"}, 64'(rresp), 64'(exp_resp));
    $display("[TB] read %s addr=%08h rdata=%08h rresp=%b", tag, addr, rdata, rresp);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check({tag, " rvalid_drop"}, 64'(rvalid), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst awready", 64'(awready), 1);
    check("rst wready",  64'(wready),  1);
    check("rst arready", 64'(arready), 1);
    check("rst bvalid",  64'(bvalid),  0);
    check("rst rvalid",  64'(rvalid),  0);
    check("rst bresp",   64'(bresp),   0);
    check("rst rresp",   64'(rresp),   0);
    check("rst rdata",   64'(rdata),   0);

    // Same-cycle AW/W write then read back.
    write_txn(32'h4, 32'hDEADBEEF, 4'hF, 2'b00, "t1_wr");
    read_txn(32'h4, 32'hDEADBEEF, 2'b00, "t1_rd");

    // W leads AW by three cycles.
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("t2 wready_hold0", 64'(wready),  0);
    check("t2 awready",      64'(awready), 1);
    check("t2 bvalid_early", 64'(bvalid),  0);
    tick();
    check("t2 wready_hold1", 64'(wready), 0);
    tick();
    check("t2 wready_hold2", 64'(wready), 0);
    awaddr = 32'h8; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("t2 bvalid",  64'(bvalid),  1);
    check("t2 bresp",   64'(bresp),   0);
    check("t2 awready", 64'(awready), 0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("t2 bvalid_drop", 64'(bvalid), 0);
    check("t2 wready_back", 64'(wready), 1);
    $display("[TB] write t2_wr addr=00000008 data=12345678 W-before-AW");
    read_txn(32'h8, 32'h12345678, 2'b00, "t2_rd");

    // Partial strobe merge.
    write_txn(32'h0, 32'hAABBCCDD, 4'hF, 2'b00, "t3_wr_full");
    write_txn(32'h0, 32'h11223344, 4'b0101, 2'b00, "t3_wr_part");
    read_txn(32'h0, 32'hAA22CC44, 2'b00, "t3_rd");

    // B back-pressure with a second write already presented.
    awaddr = 32'hC; wdata = 32'h0BADF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awaddr = 32'h10; wdata = 32'h55667788;
    for (int i = 0; i < 5; i++) begin
      check("t4 bvalid_hold",  64'(bvalid),  1);
      check("t4 bresp_hold",   64'(bresp),   0);
      check("t4 awready_low",  64'(awready), 0);
      check("t4 wready_low",   64'(wready),  0);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("t4 bvalid_after_b", 64'(bvalid),  0);
    check("t4 awready_back",   64'(awready), 1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t4 second_bvalid", 64'(bvalid), 1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    $display("[TB] write t4 back-pressure pair addr=0000000c,00000010");
    read_txn(32'hC,  32'h0BADF00D, 2'b00, "t4_rd_c");
    read_txn(32'h10, 32'h55667788, 2'b00, "t4_rd_10");

    // R back-pressure: rdata stable, no new AR accepted.
    araddr = 32'h4; arvalid = 1'b1;
    tick();
    araddr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      check("t4r rvalid_hold",  64'(rvalid),  1);
      check("t4r rdata_hold",   64'(rdata),   64'(32'hDEADBEEF));
      check("t4r arready_low",  64'(arready), 0);
      tick();
    end
    arvalid = 1'b0; rready = 1'b1;
    tick();
    rready = 1'b0;
    check("t4r rvalid_drop", 64'(rvalid), 0);
    $display("[TB] read t4r back-pressure addr=00000004 rdata=deadbeef");

    // Beyond the array: SLVERR with the check enabled, alias onto word 0 otherwise.
    write_txn(32'h40, 32'hCAFEF00D, 4'hF, OOR_RESP, "t5_wr_oor");
    read_txn(32'h40, OOR_RDATA, OOR_RESP, "t5_rd_oor");
    read_txn(32'h0,  OOR_WORD0, 2'b00,    "t5_rd_w0");

    // Write commit and read capture to the same word on the same edge.
    awaddr = 32'h4; wdata = 32'h01020304; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h4; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("t6 rvalid", 64'(rvalid), 1);
    check("t6 rdata_prewrite", 64'(rdata), 64'(32'hDEADBEEF));
    check("t6 bvalid", 64'(bvalid), 1);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    $display("[TB] write+read t6 same word addr=00000004 rdata=%08h", 32'hDEADBEEF);
    read_txn(32'h4, 32'h01020304, 2'b00, "t6_rd_post");

    // Asynchronous reset with both responses pending.
    araddr = 32'h8; arvalid = 1'b1;
    awaddr = 32'hC; wdata = 32'hFFFFFFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("t7 rvalid_pre", 64'(rvalid), 1);
    check("t7 bvalid_pre", 64'(bvalid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t7 bvalid",  64'(bvalid),  0);
    check("t7 rvalid",  64'(rvalid),  0);
    check("t7 awready", 64'(awready), 1);
    check("t7 wready",  64'(wready),  1);
    check("t7 arready", 64'(arready), 1);
    check("t7 bresp",   64'(bresp),   0);
    check("t7 rresp",   64'(rresp),   0);
    check("t7 rdata",   64'(rdata),   0);
    $display("[TB] reset t7 asserted mid-transaction");
    tick();
    rst = 1'b0;
    read_txn(32'h4, 32'h0, 2'b00, "t7_rd_4");
    read_txn(32'h8, 32'h0, 2'b00, "t7_rd_8");
    read_txn(32'hC, 32'h0, 2'b00, "t7_rd_c");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_mem.md
# axi4_lite_slave_mem

AXI4-Lite responder holding a word-addressed, byte-enabled register array, answering write and read transactions from an AXI4-Lite initiator. Write (AW/W/B) and read (AR/R) paths run as independent state machines. It is the bus-facing RTL endpoint for master-side examples and VIP-master directed tests.

## Interface
- DATA_WIDTH, 32, data bus width in bits; must be 32 or 64.
- ADDRESS_WIDTH, 32, address bus width in bits.
- MEM_DEPTH, 16, number of DATA_WIDTH words; must be a power of two.
- BASE_ADDR, 0, byte address of word 0.
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous active-high reset.
- awvalid  in  1 / awready  out  1 / awaddr  in  ADDRESS_WIDTH: write address channel.
- wvalid  in  1 / wready  out  1 / wdata  in  DATA_WIDTH / wstrb  in  DATA_WIDTH/8: write data channel.
- bvalid  out  1 / bready  in  1 / bresp  out  2: write response channel.
- arvalid  in  1 / arready  out  1 / araddr  in  ADDRESS_WIDTH: read address channel.
- rvalid  out  1 / rready  in  1 / rdata  out  DATA_WIDTH / rresp  out  2: read data channel.

## Operation
- Word index = (addr − BASE_ADDR) >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored.
- Write FSM has four states:
  - WR_IDLE: awready=1, wready=1.
  - WR_HAVE_A: address captured, waiting for data; awready=0.
  - WR_HAVE_D: data and strobes captured, waiting for address; wready=0.
  - WR_RESP: both captured; memory written; awready=wready=0; bvalid=1.
- Write transitions:
  - AW and W in the same cycle: WR_IDLE → WR_RESP.
  - AW only: → WR_HAVE_A. W only: → WR_HAVE_D.
  - Completing handshake in WR_HAVE_A or WR_HAVE_D: → WR_RESP.
  - WR_RESP → WR_IDLE on bvalid && bready.
- Memory write: byte lane i is updated only when wstrb[i]=1. wstrb=0 still completes with OKAY and leaves memory unchanged.
- Read FSM has two states:
  - RD_IDLE: arready=1.
  - RD_DATA: rvalid=1; rdata and rresp registered at entry.
- Read transitions:
  - RD_IDLE → RD_DATA on arvalid && arready.
  - RD_DATA → RD_IDLE on rvalid && rready.
- Responses: OKAY=2'b00. SLVERR=2'b10 only when AXI4LITE_SLV_ADDR_CHECK_EN is defined (see Configuration).
- Simultaneous write commit and read capture at the same edge to the same word: the read returns the pre-write data.
- Reset (including mid-transaction):
  - awready=1, wready=1, arready=1; bvalid=0, rvalid=0; bresp=0, rresp=0, rdata=0.
  - All memory words cleared to 0; holding registers cleared.
  - In-flight transactions are dropped with no response.

## Timing
- Write latency: the last of the AW/W handshakes occurs at edge N. Memory is updated and bvalid is high after edge N. The B handshake is possible in cycle N+1 at the earliest.
- Read latency: AR handshake at edge N gives rvalid and rdata valid after edge N. Read data is never combinational from araddr.
- bvalid, rvalid and the associated data/response are held stable until the handshake completes. Valids never depend combinationally on ready.
- Readies return high in the cycle after the B or R handshake. Peak throughput is one write per 2 cycles and one read per 2 cycles, running concurrently.
- Back-pressure: with bready held low, no further AW/W is accepted. With rready held low, no further AR is accepted.

## Configuration
- AXI4LITE_SLV_ADDR_CHECK_EN defined:
  - An address outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH·DATA_WIDTH/8) returns SLVERR.
  - Out-of-range writes do not modify memory.
  - Out-of-range reads return rdata=0.
- Not defined:
  - Word index is taken modulo MEM_DEPTH, so addresses alias and wrap.
  - Responses are always OKAY.

## Structure
- Package axi4_lite_slave_pkg holds:
  - response constants RESP_OKAY and RESP_SLVERR;
  - write and read FSM state typedefs;
  - the addr-to-index helper function.
- Sub-module axi4_lite_slave_regarray: MEM_DEPTH×DATA_WIDTH array with per-byte write enable, one write port, one registered read port, and async clear.
- Top level: the two FSMs, AW/W holding registers and the range check.

## Test plan
- Write 0xDEADBEEF to 0x4 with wstrb=4'hF, AW and W in the same cycle, then read 0x4 → bvalid one cycle after the handshake, bresp=00; rdata=0xDEADBEEF, rresp=00.
- W issued 3 cycles before AW (addr 0x8, data 0x12345678) → wready low until AW arrives; the B response follows one cycle after the AW handshake; a read of 0x8 returns 0x12345678.
- Write 0xAABBCCDD to word 0x0, then write 0x11223344 to 0x0 with wstrb=4'b0101 → a read of 0x0 returns 0xAA22CC44.
- Hold bready=0 for 5 cycles after a write → bvalid and bresp stay stable, awready=wready=0; a second AW is not accepted until the cycle after the B handshake.
- With the macro defined, write then read address 0x40 (MEM_DEPTH=16) → bresp=10, rresp=10, rdata=0, and word 0 is unchanged. Without the macro → OKAY responses and word 0 is overwritten.
- Assert rst while rvalid=1 and bready is pending → all valids are 0 and all readies are 1 immediately; a subsequent read of any word returns 0.
